// File: rtl/spi_stp_rx_if.sv
// spi_stp_rx_if: bundles the serial inputs from the SPI frame controller,
// the valid/ready sample output and the status signals of spi_stp_rx.
//   slave  : the receiver side (consumes cs/stp_en/miso/chansel/clr/ready,
//            drives data/chan/valid/overrun/frame_err/err_cnt)
//   master : the environment side (controller + sample consumer)
`timescale 1ns/1ps
interface spi_stp_rx_if #(
    parameter int ADC_WIDTH = 8,
    parameter int CHAN_W    = 5
);
    logic                 cs;
    logic                 stp_en;
    logic                 miso;
    logic [CHAN_W-1:0]    chansel;
    logic                 clr;
    logic [ADC_WIDTH-1:0] data;
    logic [CHAN_W-1:0]    chan;
    logic                 valid;
    logic                 ready;
    logic                 overrun;
    logic                 frame_err;
    logic [7:0]           err_cnt;

    modport slave (
        input  cs, stp_en, miso, chansel, clr, ready,
        output data, chan, valid, overrun, frame_err, err_cnt
    );

    modport master (
        output cs, stp_en, miso, chansel, clr, ready,
        input  data, chan, valid, overrun, frame_err, err_cnt
    );
endinterface

// File: rtl/spi_stp_rx.sv
// spi_stp_rx: serial-to-parallel receive stage behind the SPI frame
// controller. Shifts in one ADC_WIDTH-bit sample per cs-low frame (after
// LEAD_BITS discarded pad bits, MSB first), tags it with the channel latched
// at frame start and offers it on a valid/ready interface.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - spi_stp_rx_if.slave: cs, stp_en, miso, chansel, clr, ready in;
//          data, chan, valid, overrun, frame_err, err_cnt out
`timescale 1ns/1ps
module spi_stp_rx #(
    parameter int ADC_WIDTH = 8,
    parameter int LEAD_BITS = 4,
    parameter int CHAN_W    = 5
) (
    input  logic         clk,
    input  logic         rst,
    spi_stp_rx_if.slave  bus
);
    localparam int FRAME_BITS = LEAD_BITS + ADC_WIDTH;
    localparam int CNT_MAX    = FRAME_BITS + 1;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] C_LEAD  = CNT_W'(LEAD_BITS);

    logic                 r_cs_d;
    logic                 r_armed;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADC_WIDTH-1:0] r_shift;
    logic [CHAN_W-1:0]    r_tag;
    logic [ADC_WIDTH-1:0] r_data;
    logic [CHAN_W-1:0]    r_chan;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 r_frame_err;
    logic [7:0]           r_err_cnt;

    logic                 w_start;
    logic                 w_end;
    logic                 w_bit;
    logic                 w_good;
    logic                 w_bad;
    logic                 w_load;
    logic [CNT_W-1:0]     w_cnt_base;
    logic [ADC_WIDTH-1:0] w_shift_base;

    // Edges are only honoured once cs has been seen high, so a frame that was
    // already running when reset released is dropped without an error.
    assign w_start = r_armed & ~bus.cs & r_cs_d;
    assign w_end   = r_armed & bus.cs & ~r_cs_d;
    assign w_bit   = r_armed & ~bus.cs & bus.stp_en;

    // A bit arriving in the frame-start cycle accumulates onto the cleared state.
    assign w_cnt_base   = w_start ? '0 : r_cnt;
    assign w_shift_base = w_start ? '0 : r_shift;

    assign w_good = w_end & (r_cnt == C_FRAME);
    assign w_bad  = w_end & (r_cnt != C_FRAME);
    // A good frame loads when the holding register is empty or being drained.
    assign w_load = w_good & (~r_valid | bus.ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_d      <= 1'b0;
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_tag       <= '0;
            r_data      <= '0;
            r_chan      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_cs_d <= bus.cs;
            if (bus.cs) begin
                r_armed <= 1'b1;
            end

            if (w_start) begin
                r_tag <= bus.chansel;
            end

            if (w_bit) begin
                r_cnt <= (w_cnt_base != C_MAX) ? w_cnt_base + CNT_W'(1) : w_cnt_base;
                // Lead (pad) bits advance the counter but are not shifted in.
                if (w_cnt_base >= C_LEAD) begin
                    r_shift <= (w_shift_base << 1) | ADC_WIDTH'(bus.miso);
                end else begin
                    r_shift <= w_shift_base;
                end
            end else if (w_start) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end

            if (w_load) begin
                r_data  <= r_shift;
                r_chan  <= r_tag;
                r_valid <= 1'b1;
            end else if (r_valid & bus.ready) begin
                r_valid <= 1'b0;
            end

            // Events take priority over clr.
            if (w_good & r_valid & ~bus.ready) begin
                r_overrun <= 1'b1;
            end else if (bus.clr) begin
                r_overrun <= 1'b0;
            end

            r_frame_err <= w_bad;

            if (w_bad) begin
                if (bus.clr) begin
                    r_err_cnt <= 8'd1;
                end else if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (bus.clr) begin
                r_err_cnt <= 8'd0;
            end
        end
    end

    assign bus.data      = r_data;
    assign bus.chan      = r_chan;
    assign bus.valid     = r_valid;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;
    assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_spi_stp_rx.sv
// tb_spi_stp_rx: self-checking bench for spi_stp_rx. A table of frames is
// driven with ready held high; delivered samples are compared against a
// scoreboard queue filled when each good frame is driven. Hand-written
// sequences cover overrun/clr, reset mid-frame, err_cnt saturation and
// clr-versus-error priority.
`timescale 1ns/1ps
module tb_spi_stp_rx;
    logic clk;
    logic rst;

    spi_stp_rx_if #(.ADC_WIDTH(8), .CHAN_W(5)) bus ();

    spi_stp_rx #(.ADC_WIDTH(8), .LEAD_BITS(4), .CHAN_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [12:0] sb[$];

    // Values observed right after the first cs-high edge, and one edge later.
    logic       o_valid, o_ferr, o_valid2, o_ferr2;
    logic [7:0] o_data, o_errcnt;
    logic [4:0] o_chan;
    int         exp_ec;

    typedef struct {
        logic [4:0] ch;
        logic [7:0] smp;
        int         nstp;
        int         gap;
        bit         err;
        bit         vld;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cs-low frame: idle cycles then nstp stp_en cycles carrying
    // 4 zero pad bits and smp MSB first, then gap cs-high cycles.
    task automatic frame(input logic [4:0] ch, input logic [7:0] smp, input int nstp,
                         input int gap, input bit push, input bit clr_end);
        int lowlen;
        int first;
        int k;
        lowlen = (nstp > 12) ? nstp + 6 : 18;
        first  = lowlen - nstp;
        if (push) sb.push_back({ch, smp});
        for (int i = 0; i < lowlen; i++) begin
            bus.cs      = 1'b0;
            bus.chansel = ch;
            if (i >= first) begin
                k          = i - first;
                bus.stp_en = 1'b1;
                bus.miso   = (k >= 4 && k < 12) ? smp[11-k] : 1'b0;
            end else begin
                bus.stp_en = 1'b0;
                bus.miso   = 1'b0;
            end
            step();
        end
        bus.cs     = 1'b1;
        bus.stp_en = 1'b0;
        bus.miso   = 1'b0;
        bus.clr    = clr_end;
        step();
        bus.clr  = 1'b0;
        o_valid  = bus.valid;
        o_ferr   = bus.frame_err;
        o_data   = bus.data;
        o_chan   = bus.chan;
        o_errcnt = bus.err_cnt;
        o_valid2 = 1'b0;
        o_ferr2  = 1'b0;
        for (int g = 1; g < gap; g++) begin
            step();
            if (g == 1) begin
                o_valid2 = bus.valid;
                o_ferr2  = bus.frame_err;
            end
        end
    endtask

    // Scoreboard: every accepted sample must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && bus.valid && bus.ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h required=none", {bus.chan, bus.data});
            end else begin
                chk("sb_sample", {19'd0, bus.chan, bus.data}, {19'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{5'b11000, 8'hA5, 12, 2, 1'b0, 1'b1};
        vt[1] = '{5'b00011, 8'h3C, 12, 1, 1'b0, 1'b1};
        vt[2] = '{5'b10101, 8'hC3, 12, 2, 1'b0, 1'b1};
        vt[3] = '{5'b00111, 8'h00, 11, 2, 1'b1, 1'b0};
        vt[4] = '{5'b01110, 8'h96, 12, 2, 1'b0, 1'b1};
        vt[5] = '{5'b11111, 8'hFF, 13, 2, 1'b1, 1'b0};
        vt[6] = '{5'b00001, 8'h00,  0, 2, 1'b1, 1'b0};
        vt[7] = '{5'b10000, 8'h01, 12, 2, 1'b0, 1'b1};

        rst         = 1'b1;
        bus.cs      = 1'b1;
        bus.stp_en  = 1'b0;
        bus.miso    = 1'b0;
        bus.chansel = '0;
        bus.clr     = 1'b0;
        bus.ready   = 1'b1;
        exp_ec      = 0;
        step();
        step();
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_data", {24'd0, bus.data}, 32'd0);
        chk("rst_chan", {27'd0, bus.chan}, 32'd0);
        chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            frame(vt[i].ch, vt[i].smp, vt[i].nstp, vt[i].gap, vt[i].vld, 1'b0);
            if (vt[i].err && exp_ec < 255) exp_ec++;
            chk($sformatf("vec%0d_valid", i), {31'd0, o_valid}, {31'd0, vt[i].vld});
            chk($sformatf("vec%0d_frame_err", i), {31'd0, o_ferr}, {31'd0, vt[i].err});
            chk($sformatf("vec%0d_err_cnt", i), {24'd0, o_errcnt}, exp_ec);
            chk($sformatf("vec%0d_overrun", i), {31'd0, bus.overrun}, 32'd0);
            if (vt[i].vld) begin
                chk($sformatf("vec%0d_data", i), {24'd0, o_data}, {24'd0, vt[i].smp});
                chk($sformatf("vec%0d_chan", i), {27'd0, o_chan}, {27'd0, vt[i].ch});
            end
            if (vt[i].gap >= 2) begin
                chk($sformatf("vec%0d_valid_drop", i), {31'd0, o_valid2}, 32'd0);
                chk($sformatf("vec%0d_ferr_pulse", i), {31'd0, o_ferr2}, 32'd0);
            end
        end

        // Overrun: second sample dropped while the first is held.
        bus.ready = 1'b0;
        frame(5'h04, 8'h11, 12, 2, 1'b1, 1'b0);
        chk("ovr_first_valid", {31'd0, o_valid}, 32'd1);
        chk("ovr_first_data", {24'd0, o_data}, 32'h11);
        frame(5'h09, 8'h22, 12, 2, 1'b0, 1'b0);
        chk("ovr_hold_data", {24'd0, bus.data}, 32'h11);
        chk("ovr_hold_chan", {27'd0, bus.chan}, 32'h04);
        chk("ovr_hold_valid", {31'd0, bus.valid}, 32'd1);
        chk("ovr_flag", {31'd0, bus.overrun}, 32'd1);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        exp_ec  = 0;
        chk("ovr_clr", {31'd0, bus.overrun}, 32'd0);
        chk("ovr_clr_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
        chk("ovr_clr_valid", {31'd0, bus.valid}, 32'd1);
        bus.ready = 1'b1;
        step();
        chk("ovr_drain_valid", {31'd0, bus.valid}, 32'd0);

        // Make err_cnt nonzero so the mid-frame reset visibly clears it.
        frame(5'h00, 8'h00, 11, 2, 1'b0, 1'b0);
        chk("pre_rst_err_cnt", {24'd0, bus.err_cnt}, 32'd1);

        // Reset at cs-low cycle 8; rest of that frame must be ignored.
        for (int i = 0; i < 18; i++) begin
            bus.cs      = 1'b0;
            bus.chansel = 5'h12;
            bus.stp_en  = (i >= 6);
            bus.miso    = (i >= 10) ? ~bus.miso : 1'b0;
            rst         = (i == 7);
            step();
            if (i == 7) begin
                chk("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
                chk("mid_rst_data", {24'd0, bus.data}, 32'd0);
                chk("mid_rst_chan", {27'd0, bus.chan}, 32'd0);
                chk("mid_rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
                chk("mid_rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
            end
        end
        rst        = 1'b0;
        bus.cs     = 1'b1;
        bus.stp_en = 1'b0;
        bus.miso   = 1'b0;
        step();
        chk("mid_rst_end_valid", {31'd0, bus.valid}, 32'd0);
        chk("mid_rst_end_ferr", {31'd0, bus.frame_err}, 32'd0);
        step();
        chk("mid_rst_end_ferr2", {31'd0, bus.frame_err}, 32'd0);
        frame(5'h1B, 8'h5A, 12, 2, 1'b1, 1'b0);
        chk("post_rst_valid", {31'd0, o_valid}, 32'd1);
        chk("post_rst_data", {24'd0, o_data}, 32'h5A);
        chk("post_rst_chan", {27'd0, o_chan}, 32'h1B);
        chk("post_rst_err_cnt", {24'd0, o_errcnt}, 32'd0);

        // Saturation of err_cnt, then clr coinciding with an error.
        for (int i = 0; i < 260; i++) begin
            frame(5'h00, 8'h00, 11, 1, 1'b0, 1'b0);
        end
        step();
        chk("sat_err_cnt", {24'd0, bus.err_cnt}, 32'd255);
        frame(5'h00, 8'h00, 11, 2, 1'b0, 1'b1);
        chk("clr_prio_err_cnt", {24'd0, o_errcnt}, 32'd1);
        chk("clr_prio_ferr", {31'd0, o_ferr}, 32'd1);

        step();
        step();
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_stp_rx.md
Name: spi_stp_rx

Overview:
- Serial-to-parallel receive stage directly downstream of the SPI frame controller.
- Consumes that controller's cs, stp_en and chansel, together with the ADC MISO line.
- Assembles one ADC_WIDTH-bit sample per frame and tags it with its channel.
- Presents the sample on a valid/ready interface to the sample-processing logic, with overrun and frame-error reporting.

Parameters:
- ADC_WIDTH, 8: sample width in bits; MSB is received first.
- LEAD_BITS, 4: stp_en cycles at the start of the serial-in phase that are discarded (null/pad bits).
- CHAN_W, 5: width of the chansel/chan tag.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  active-low frame select from the controller.
- stp_en  in  1  serial-in enable; high for one cycle per received bit.
- miso  in  1  ADC serial data, already in the clk domain.
- chansel  in  CHAN_W  channel select driven for the current frame.
- clr  in  1  synchronous clear of overrun and err_cnt.
- data  out  ADC_WIDTH  received sample.
- chan  out  CHAN_W  channel tag of data.
- valid  out  1  data/chan hold an unconsumed sample.
- ready  in  1  consumer accepts when valid&ready at a clock edge.
- overrun  out  1  sticky: a good sample was dropped.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- err_cnt  out  8  saturating count of frame errors.

Behaviour:
- Reset (rst=1 at an edge): data=0, chan=0, valid=0, overrun=0, frame_err=0, err_cnt=0; shift register, bit counter, cs_d and armed all cleared. rst overrides every other input.
- cs_d is cs registered.
- Frame start: cs=0 & cs_d=1.
- Frame end: cs=1 & cs_d=0.
- armed is set on any cycle with cs=1 and stays set until reset. A frame start or frame end is acted on only while armed=1, so a frame already in progress at reset release is ignored silently: no sample, no error.
- At frame start:
  - bit counter cleared to 0, shift register cleared.
  - chansel latched into the internal tag register.
  - if stp_en=1 in that same cycle, the bit is also captured as bit 0.
- Each cycle with cs=0 & stp_en=1 & armed:
  - bit counter increments, saturating at LEAD_BITS+ADC_WIDTH+1.
  - if counter >= LEAD_BITS before the increment, shift left and insert miso at the LSB.
- stp_en while cs=1 is ignored.
- Frame evaluation at the frame-end edge; the frame is good iff the counter equals LEAD_BITS+ADC_WIDTH exactly.
  - Good frame, and valid=0 or (valid=1 & ready=1): load data and chan; valid=1 on the next cycle. Latency is one cycle after the first cs-high cycle.
  - Good frame, valid=1 & ready=0: new sample dropped; held data/chan unchanged; overrun set.
  - Bad frame: no load; frame_err=1 for exactly the next cycle; err_cnt increments, saturating at 255.
- Handshake:
  - valid stays high and data/chan stay stable until valid&ready is seen at an edge; valid falls on the next cycle.
  - If a good frame end coincides with the accept, the new sample loads and valid stays 1 without a gap.
- clr: overrun=0 and err_cnt=0 at the next edge. If clr coincides with an overrun or error event, the event wins: overrun=1, err_cnt=1.
- A one-cycle cs-high gap between back-to-back frames is supported: frame end and the next frame start are on consecutive cycles.
- A frame with cs=0 and stp_en never asserted is a bad frame (count 0).

Test Plan:
- Nominal frame: cs low 18 cycles; stp_en in the last 12; miso = 0000 then 1010_0101; chansel=11000 -> one cycle after the first cs-high cycle, data=0xA5, chan=11000, valid=1; with ready=1 held, valid drops the cycle after.
- Back-to-back: two frames with a 1-cycle cs gap, samples 0x3C then 0xC3, ready tied 1 -> valid pulses twice, data 0x3C then 0xC3, overrun=0.
- Overrun: ready=0; frames 0x11 then 0x22 -> data stays 0x11, overrun=1. Pulse clr -> overrun=0. Raise ready -> 0x11 consumed, valid=0.
- Short frame: stp_en for only 11 cycles -> no valid; frame_err pulses 1 cycle; err_cnt=1. A following good frame delivers normally.
- Reset mid-frame: rst asserted for 1 cycle at cs-low cycle 8 -> all outputs 0; the remainder of that frame gives no valid and no frame_err; the next full frame gives a correct sample.
- Saturation and clr priority: 260 short frames -> err_cnt=255. clr coinciding with a bad frame end -> err_cnt=1.
